// File: rtl/freelist_mw.sv
// Shared multi-way physical-register free list for rename: a circular pool
// with up to WAYS allocations and WAYS frees per cycle, plus branch checkpoints.
module freelist_mw #(
  parameter  int WIDTH    = 7,
  parameter  int NUM_ARCH = 32,
  parameter  int WAYS     = 4,
  parameter  int NUM_BR   = 8,
  localparam int DEPTH    = (1 << WIDTH) - NUM_ARCH,
  localparam int BW       = (NUM_BR > 1) ? $clog2(NUM_BR) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WAYS-1:0]       i_re,
  output logic [WAYS*WIDTH-1:0] o_prd,
  output logic                  o_ready,
  input  logic [WAYS-1:0]       i_we,
  input  logic [WAYS*WIDTH-1:0] i_data,
  input  logic                  i_save,
  input  logic [BW-1:0]         i_save_tag,
  input  logic                  i_restore,
  input  logic [BW-1:0]         i_restore_tag,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_overflow
);

  // Pointers, counts and register numbers all fit in WIDTH bits since DEPTH < 2^WIDTH.
  typedef logic [WIDTH-1:0] ptr_t;
  typedef logic [WIDTH:0]   wide_t;

  ptr_t              mem [DEPTH];
  ptr_t              head_q, tail_q, count_q;
  logic              overflow_q;
  logic [NUM_BR-1:0] ck_valid_q;
  ptr_t              ck_head_q  [NUM_BR];
  ptr_t              ck_alloc_q [NUM_BR];

  logic              alloc_en, restore_hit, drop;
  ptr_t              n_alloc, n_free;
  ptr_t              head_next, tail_next, count_next;
  logic [WAYS-1:0]   wr_en;
  ptr_t              wr_addr [WAYS];

  // Modulo-DEPTH add; callers guarantee base < DEPTH and off <= DEPTH.
  function automatic ptr_t wrap_add(input ptr_t base, input wide_t off);
    wide_t sum;
    sum = wide_t'(base) + off;
    if (sum >= wide_t'(DEPTH)) sum = sum - wide_t'(DEPTH);
    return ptr_t'(sum);
  endfunction

  assign o_ready     = (count_q >= ptr_t'(WAYS));
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign restore_hit = i_restore && ck_valid_q[i_restore_tag];
  assign alloc_en    = o_ready && !i_restore;

  // NOTE: every variable assigned in an always_comb gets a default before any
  // conditional logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : read_lanes
    ptr_t rank;
    rank  = '0;
    o_prd = '0;
    for (int k = 0; k < WAYS; k++) begin
      o_prd[k*WIDTH +: WIDTH] = mem[wrap_add(head_q, wide_t'(rank))];
      if (i_re[k]) rank = rank + ptr_t'(1);
    end
    n_alloc = alloc_en ? rank : '0;
  end

  // Frees are accepted in lane order until the pool would exceed DEPTH.
  always_comb begin : free_lanes
    ptr_t  rank;
    wide_t base;
    wide_t space;
    base  = restore_hit ? wide_t'(count_q) + wide_t'(ck_alloc_q[i_restore_tag])
                        : wide_t'(count_q);
    space = (base >= wide_t'(DEPTH)) ? '0 : wide_t'(DEPTH) - base;
    rank  = '0;
    drop  = 1'b0;
    wr_en = '0;
    for (int k = 0; k < WAYS; k++) begin
      wr_addr[k] = wrap_add(tail_q, wide_t'(rank));
      if (i_we[k]) begin
        if (wide_t'(rank) < space) begin
          wr_en[k] = 1'b1;
          rank     = rank + ptr_t'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
    n_free = rank;
  end

  always_comb begin : next_state
    head_next  = wrap_add(head_q, wide_t'(n_alloc));
    count_next = count_q - n_alloc + n_free;
    if (restore_hit) begin
      head_next  = ck_head_q[i_restore_tag];
      count_next = count_q + ck_alloc_q[i_restore_tag] + n_free;
    end
    tail_next = wrap_add(tail_q, wide_t'(n_free));
  end

  // NOTE: the pool must come out of reset already holding P(NUM_ARCH)..P(2^WIDTH-1),
  // so unlike an ordinary RAM this storage array is explicitly reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ptr_t'(NUM_ARCH + i);
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= ptr_t'(DEPTH);
      overflow_q <= 1'b0;
      ck_valid_q <= '0;
      for (int b = 0; b < NUM_BR; b++) begin
        ck_head_q[b]  <= '0;
        ck_alloc_q[b] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples this cycle's values, independent of statement order.
      for (int k = 0; k < WAYS; k++)
        if (wr_en[k]) mem[wr_addr[k]] <= i_data[k*WIDTH +: WIDTH];
      head_q  <= head_next;
      tail_q  <= tail_next;
      count_q <= count_next;
      if (drop) overflow_q <= 1'b1;
      for (int b = 0; b < NUM_BR; b++) begin
        if (i_restore) begin
          ck_valid_q[b] <= 1'b0;
        end else if (i_save && (i_save_tag == BW'(b))) begin
          ck_valid_q[b] <= 1'b1;
          ck_head_q[b]  <= head_next;
          ck_alloc_q[b] <= '0;
        end else if (ck_valid_q[b]) begin
          ck_alloc_q[b] <= ck_alloc_q[b] + n_alloc;
        end
      end
    end
  end

endmodule
